// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared encodings for the program-counter sequencer
package pc_pkg;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - combinational next-PC candidate mux and alignment check
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int INC     = 4,
    parameter int IMM_W   = 16,
    parameter int JADDR_W = 26
) (
    input  logic [WIDTH-1:0]   curpc,
    input  logic [1:0]         pcsrc,
    input  logic [IMM_W-1:0]   immediate,
    input  logic [JADDR_W-1:0] jumpaddr,
    input  logic [WIDTH-1:0]   regtarget,
    input  logic               halted,
    output logic [WIDTH-1:0]   candidate,
    output logic [WIDTH-1:0]   nextpc,
    output logic               reg_misaligned
);

    localparam int S  = $clog2(INC);
    localparam int JW = JADDR_W + S;

    logic [WIDTH-1:0] seq;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] branch_c;
    logic [WIDTH-1:0] jump_c;

    assign seq      = curpc + WIDTH'(INC);
    assign imm_ext  = WIDTH'($signed(immediate));
    assign branch_c = seq + (imm_ext << S);

    // The jump field keeps the upper segment of seq only when it is narrower than the PC.
    generate
        if (JW >= WIDTH) begin : g_jump_full
            assign jump_c = WIDTH'(jumpaddr) << S;
        end else begin : g_jump_region
            assign jump_c = {seq[WIDTH-1:JW], JW'(jumpaddr) << S};
        end
    endgenerate

    always_comb begin
        candidate = seq;
        case (pcsrc)
            PC_SEQ:    candidate = seq;
            PC_BRANCH: candidate = branch_c;
            PC_JUMP:   candidate = jump_c;
            PC_REG:    candidate = regtarget;
            default:   candidate = seq;
        endcase
    end

    assign reg_misaligned = (regtarget & WIDTH'(INC - 1)) != '0;
    assign nextpc         = halted ? seq : candidate;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, RUN/HALT FSM and saturating retired counter
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               INC          = 4,
    parameter int               IMM_W        = 16,
    parameter int               JADDR_W      = 26,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               CNT_W        = 32
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               PCWre,
    input  logic [1:0]         PCSrc,
    input  logic [IMM_W-1:0]   immediate,
    input  logic [JADDR_W-1:0] jumpAddr,
    input  logic [WIDTH-1:0]   regTarget,
    input  logic               halt,
    output logic [WIDTH-1:0]   curPC,
    output logic [WIDTH-1:0]   nextPC,
    output logic               halted,
    output logic               misaligned,
    output logic [CNT_W-1:0]   retired
);

    pc_state_t        state, state_n;
    logic [WIDTH-1:0] pc_q, pc_n;
    logic             mis_q, mis_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [WIDTH-1:0] candidate;
    logic             reg_misaligned;

    pc_target_calc #(
        .WIDTH   (WIDTH),
        .INC     (INC),
        .IMM_W   (IMM_W),
        .JADDR_W (JADDR_W)
    ) u_target (
        .curpc          (pc_q),
        .pcsrc          (PCSrc),
        .immediate      (immediate),
        .jumpaddr       (jumpAddr),
        .regtarget      (regTarget),
        .halted         (state == ST_HALT),
        .candidate      (candidate),
        .nextpc         (nextPC),
        .reg_misaligned (reg_misaligned)
    );

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state <= ST_RUN;
            pc_q  <= RESET_VECTOR;
            mis_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state <= state_n;
            pc_q  <= pc_n;
            mis_q <= mis_n;
            cnt_q <= cnt_n;
        end
    end

    // Priority in RUN: halt request, stall, register-jump trap, then update.
    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        mis_n   = mis_q;
        cnt_n   = cnt_q;
        if (state == ST_RUN) begin
            if (halt) begin
                state_n = ST_HALT;
            end else if (!PCWre) begin
                state_n = ST_RUN;
            end else if (PCSrc == PC_REG && reg_misaligned) begin
                mis_n   = 1'b1;
                state_n = ST_HALT;
            end else begin
                pc_n = candidate;
                if (cnt_q != '1) begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign curPC      = pc_q;
    assign halted     = (state == ST_HALT);
    assign misaligned = mis_q;
    assign retired    = cnt_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised, clocked program-counter unit for the single-cycle CPU. It holds the PC register and computes the next PC from four sources: sequential increment, PC-relative branch, pseudo-direct jump and register jump. It adds a stall enable, a sticky HALT state, a misaligned-target trap and a saturating retired-instruction counter. It sits between the control unit (PCWre, PCSrc, halt) and instruction memory (curPC).

Parameters:
WIDTH, 32, PC and address width in bits (>= 8)
INC, 4, sequential increment in bytes; must be a power of two
IMM_W, 16, branch immediate width; sign-extended and shifted left by log2(INC)
JADDR_W, 26, jump target field width; shifted left by log2(INC)
RESET_VECTOR, 0, PC value loaded on reset; must be INC-aligned
CNT_W, 32, retired-instruction counter width

Ports:
CLK  input  1  system clock; all state updates on rising edge
Reset  input  1  synchronous, active-low reset (Reset==0 at a CLK rising edge resets)
PCWre  input  1  PC write enable; 0 = stall, hold PC
PCSrc  input  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 register
immediate  input  IMM_W  branch offset in instructions, two's complement
jumpAddr  input  JADDR_W  jump target field
regTarget  input  WIDTH  register-jump target (byte address)
halt  input  1  request to stop fetching
curPC  output  WIDTH  registered current PC
nextPC  output  WIDTH  combinational candidate next PC (PC+INC when halted)
halted  output  1  registered; 1 in HALT state
misaligned  output  1  registered sticky trap flag
retired  output  CNT_W  registered count of PC updates

Behaviour:
- Reset (Reset==0 at edge): curPC=RESET_VECTOR, state=RUN, halted=0, misaligned=0, retired=0. Reset overrides every other input, including in HALT.
- S = log2(INC); seq = curPC+INC, modulo 2^WIDTH (wraps silently).
- Candidates: 00 -> seq; 01 -> seq + (sign_ext(immediate) << S); 10 -> {seq[WIDTH-1 : JADDR_W+S], jumpAddr, S'b0}; 11 -> regTarget. When JADDR_W+S >= WIDTH, the jump candidate is the low WIDTH bits of {jumpAddr, S'b0}.
- All arithmetic is WIDTH bits, two's complement, and wraps modulo 2^WIDTH.
- States: RUN, HALT. There is no STALL state; a stall is RUN with PCWre=0.
- In RUN, the first matching rule below applies at each edge:
  1. halt=1: go to HALT, halted=1, curPC held, retired unchanged. This applies regardless of PCWre.
  2. PCWre=0: hold curPC and retired.
  3. PCSrc=11 and regTarget[S-1:0] != 0: curPC held, misaligned=1, go to HALT, halted=1.
  4. Otherwise: curPC = candidate, retired += 1, saturating at 2^CNT_W-1.
- In HALT: all inputs except Reset are ignored; outputs are frozen. Only Reset leaves HALT.
- Branch and jump candidates are aligned by construction; only PCSrc=11 can trap.
- Latency: a selected target appears on curPC one cycle after the enabling edge.
- nextPC is combinational from curPC and the inputs. Its only consumers are debug and trace logic; no state uses it.

Decomposition:
- Shared package pc_pkg holds:
  - PCSrc encodings PC_SEQ=2'b00, PC_BRANCH=2'b01, PC_JUMP=2'b10, PC_REG=2'b11.
  - State encodings ST_RUN, ST_HALT.
- One natural sub-module, pc_target_calc: purely combinational candidate/next-PC mux plus the alignment check. The top level keeps the PC register, the FSM and the counter.

Test Plan:
- Reset, then 3 cycles with PCWre=1, PCSrc=00 -> curPC 0x0,0x4,0x8,0xC; retired 0..3. Assert Reset=0 mid-run -> curPC=0, retired=0 on the next edge.
- From curPC=0x100: PCSrc=01, immediate=16'hFFFE -> curPC=0xFC. Then PCSrc=01, immediate=16'h0003 -> curPC=0x10C.
- From curPC=0x1000_0010: PCSrc=10, jumpAddr=26'h0000040 -> curPC=0x1000_0100. From curPC=0xFFFF_FFFC with PCSrc=00 -> curPC wraps to 0x0.
- PCWre=0 for 2 cycles at curPC=0x20 with PCSrc=11, regTarget=0x80 -> curPC stays 0x20, retired unchanged. Then PCWre=1 -> curPC=0x80.
- PCSrc=11, regTarget=0x82 -> misaligned=1, halted=1, curPC unchanged. Further PCWre/PCSrc activity -> no change. Reset=0 -> flags clear, curPC=RESET_VECTOR.
- halt=1 together with PCWre=1 and PCSrc=00 -> halted=1, curPC not incremented. With CNT_W=2, run 5 updates -> retired saturates at 3.
